mux_sweep_checker: RTL and testbench

//  Self-checking stimulus and response stage for the 2:1 select mux z = c ? b : a.

---
 rtl/mux_sweep_checker_if.sv | 27 ++
 rtl/mux_sweep_checker.sv | 115 +++++++++++
 tb/tb_mux_sweep_checker.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mux_sweep_checker_if.sv
// Bundle between the sweep checker and the 2:1 mux under test.
// slave is the checker side; master is the mux/host side that drives start and z.
interface mux_sweep_checker_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             a;
    logic             b;
    logic             c;
    logic             z;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;
    logic             err_valid;
    logic [2:0]       err_vec;

    modport slave (
        input  start, z,
        output a, b, c, busy, done, pass_cnt, fail_cnt, err_valid, err_vec
    );

    modport master (
        output start, z,
        input  a, b, c, busy, done, pass_cnt, fail_cnt, err_valid, err_vec
    );
endinterface

// File: rtl/mux_sweep_checker.sv
// Drives all eight a/b/c combinations into a 2:1 mux, samples z after a settle
// window and keeps saturating pass/fail counts plus the first failing vector.
module mux_sweep_checker #(
    parameter int SETTLE_CYCLES = 1,
    parameter int NUM_PASSES    = 1,
    parameter int CNT_W         = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mux_sweep_checker_if.slave   bus
);
    localparam int SE = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
    localparam int SW = $clog2(SE + 1);
    localparam int PW = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    state_t           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [PW-1:0]    pidx_q, pidx_d;
    logic [SW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] pass_q, pass_d;
    logic [CNT_W-1:0] fail_q, fail_d;
    logic             errv_q, errv_d;
    logic [2:0]       errvec_q, errvec_d;

    logic expected, mismatch, last_pass;

    assign expected  = idx_q[0] ? idx_q[1] : idx_q[2];
    assign mismatch  = (bus.z != expected);
    assign last_pass = (pidx_q == PW'(NUM_PASSES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            pidx_q   <= '0;
            cnt_q    <= '0;
            pass_q   <= '0;
            fail_q   <= '0;
            errv_q   <= 1'b0;
            errvec_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            pidx_q   <= pidx_d;
            cnt_q    <= cnt_d;
            pass_q   <= pass_d;
            fail_q   <= fail_d;
            errv_q   <= errv_d;
            errvec_q <= errvec_d;
        end
    end

    // The accept edge loads SE and later vectors reload SE-1, with the exit on zero:
    // the first vector gets one extra settle cycle, giving 1+8*P*(S+1) edges to done.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        pidx_d   = pidx_q;
        cnt_d    = cnt_q;
        pass_d   = pass_q;
        fail_d   = fail_q;
        errv_d   = errv_q;
        errvec_d = errvec_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d  = SETTLE;
                    idx_d    = '0;
                    pidx_d   = '0;
                    cnt_d    = SW'(SE);
                    pass_d   = '0;
                    fail_d   = '0;
                    errv_d   = 1'b0;
                    errvec_d = '0;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) state_d = SAMPLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            SAMPLE: begin
                if (mismatch) begin
                    if (fail_q != '1) fail_d = fail_q + 1'b1;
                    if (!errv_q) begin
                        errv_d   = 1'b1;
                        errvec_d = idx_q;
                    end
                end else if (pass_q != '1) begin
                    pass_d = pass_q + 1'b1;
                end
                if (idx_q == 3'd7 && last_pass) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) pidx_d = pidx_q + 1'b1;
                    cnt_d   = SW'(SE - 1);
                    state_d = SETTLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.a         = idx_q[2];
    assign bus.b         = idx_q[1];
    assign bus.c         = idx_q[0];
    assign bus.busy      = (state_q == SETTLE) || (state_q == SAMPLE);
    assign bus.done      = (state_q == DONE);
    assign bus.pass_cnt  = pass_q;
    assign bus.fail_cnt  = fail_q;
    assign bus.err_valid = errv_q;
    assign bus.err_vec   = errvec_q;
endmodule

// File: tb/tb_mux_sweep_checker.sv
// Directed bench: default checker against ideal, stuck-0 and inverted muxes,
// ignored restart, mid-run reset, plus a two-pass/three-cycle-settle instance.
module tb_mux_sweep_checker;
    logic clk = 1'b0;
    logic rst_n;
    int   zmode;
    int   checks = 0;
    int   errors = 0;
    int   edges;

    always #5 clk = ~clk;

    mux_sweep_checker_if #(.CNT_W(8)) b1 ();
    mux_sweep_checker_if #(.CNT_W(8)) b2 ();

    mux_sweep_checker dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
    mux_sweep_checker #(.SETTLE_CYCLES(3), .NUM_PASSES(2), .CNT_W(8))
        dut2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));

    // zmode: 0 ideal mux, 1 output stuck at 0, 2 inverted mux
    assign b1.z = (zmode == 0) ? (b1.c ? b1.b : b1.a) :
                  (zmode == 1) ? 1'b0 : ~(b1.c ? b1.b : b1.a);
    assign b2.z = b2.c ? b2.b : b2.a;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pulse start, then count edges until done; optional stray start at edge restart_at.
    task automatic run1(input int restart_at, output int n);
        n = -1;
        b1.start = 1'b1;
        @(posedge clk); #1;
        b1.start = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk); #1;
            if (k == restart_at)     b1.start = 1'b1;
            if (k == restart_at + 1) b1.start = 1'b0;
            if (b1.done) begin
                n = k;
                break;
            end
        end
        if (n < 0) begin
            errors++;
            $display("FAIL run1_timeout: observed no done expected done at edge 17");
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        zmode    = 0;
        b1.start = 1'b0;
        b2.start = 1'b0;
        #1;
        check("rst_abc",   {b1.a, b1.b, b1.c}, 0);
        check("rst_busy",  b1.busy, 0);
        check("rst_done",  b1.done, 0);
        check("rst_pass",  b1.pass_cnt, 0);
        check("rst_fail",  b1.fail_cnt, 0);
        check("rst_errv",  b1.err_valid, 0);
        check("rst_errvec", b1.err_vec, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // T1: ideal mux
        run1(-10, edges);
        check("t1_latency", edges, 17);
        check("t1_pass",    b1.pass_cnt, 8);
        check("t1_fail",    b1.fail_cnt, 0);
        check("t1_errv",    b1.err_valid, 0);
        check("t1_busy",    b1.busy, 0);
        check("t1_abc",     {b1.a, b1.b, b1.c}, 3'b111);
        repeat (3) @(posedge clk);
        #1 check("t1_done_hold", b1.done, 1);

        // T2: z stuck at 0; expected is 1 for idx 3,4,6,7
        zmode = 1;
        run1(-10, edges);
        check("t2_latency", edges, 17);
        check("t2_pass",    b1.pass_cnt, 4);
        check("t2_fail",    b1.fail_cnt, 4);
        check("t2_errv",    b1.err_valid, 1);
        check("t2_errvec",  b1.err_vec, 3'b011);

        // T3: inverted mux
        zmode = 2;
        run1(-10, edges);
        check("t3_pass",    b1.pass_cnt, 0);
        check("t3_fail",    b1.fail_cnt, 8);
        check("t3_errvec",  b1.err_vec, 3'b000);

        // T5: stray start mid-run is ignored
        zmode = 0;
        run1(5, edges);
        check("t5_latency", edges, 17);
        check("t5_pass",    b1.pass_cnt, 8);
        check("t5_fail",    b1.fail_cnt, 0);
        check("t5_errv",    b1.err_valid, 0);

        // T6: asynchronous reset mid-sweep
        zmode = 1;
        b1.start = 1'b1;
        @(posedge clk); #1;
        b1.start = 1'b0;
        repeat (9) @(posedge clk);
        #1 check("t6_busy_before", b1.busy, 1);
        #1 rst_n = 1'b0;
        #1;
        check("t6_abc",   {b1.a, b1.b, b1.c}, 0);
        check("t6_busy",  b1.busy, 0);
        check("t6_done",  b1.done, 0);
        check("t6_pass",  b1.pass_cnt, 0);
        check("t6_fail",  b1.fail_cnt, 0);
        check("t6_errv",  b1.err_valid, 0);
        check("t6_errvec", b1.err_vec, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        zmode = 0;
        @(posedge clk); #1;
        run1(-10, edges);
        check("t6_latency", edges, 17);
        check("t6_pass2",   b1.pass_cnt, 8);
        check("t6_fail2",   b1.fail_cnt, 0);

        // T4: two passes, settle 3; each vector visible from edge 1+4m
        edges = -1;
        b2.start = 1'b1;
        @(posedge clk); #1;
        b2.start = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk); #1;
            if (k <= 64 && ((k - 1) % 4) == 0)
                check("t4_abc_step", {b2.a, b2.b, b2.c}, ((k - 1) / 4) % 8);
            if (b2.done) begin
                edges = k;
                break;
            end
        end
        if (edges < 0) begin
            errors++;
            $display("FAIL t4_timeout: observed no done expected done at edge 65");
        end
        check("t4_latency", edges, 65);
        check("t4_pass",    b2.pass_cnt, 16);
        check("t4_fail",    b2.fail_cnt, 0);
        check("t4_abc_end", {b2.a, b2.b, b2.c}, 3'b111);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
